seg7_para_bcd: RTL and testbench

- Recovers BCD digits from a multiplexed 7-segment display bus, the reverse of the BCD-to-7-segment encoders that drive our displays.
- Sits on the display side of the board: samples segment and digit-select lines, filters glitches with a stability counter, and decodes each pattern back to BCD.
- Delivers a complete N-digit frame to a consumer through a valid/ack handshake.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_decod.sv | 33 +++
 rtl/seg7_para_bcd.sv | 181 ++++++++++++++++++
 tb/tb_seg7_para_bcd.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for recovering BCD digits from a 7-segment display bus.
// Segment codes are written with segment a as the MSB and dp as the LSB (always 0 here).
package seg7_pkg;

  localparam logic [7:0] SEG_0       = 8'hFC;
  localparam logic [7:0] SEG_1       = 8'h60;
  localparam logic [7:0] SEG_2       = 8'hDA;
  localparam logic [7:0] SEG_3       = 8'hF2;
  localparam logic [7:0] SEG_4       = 8'h66;
  localparam logic [7:0] SEG_5       = 8'hB6;
  localparam logic [7:0] SEG_6       = 8'hBE;
  localparam logic [7:0] SEG_7       = 8'hE0;
  localparam logic [7:0] SEG_8       = 8'hFE;
  localparam logic [7:0] SEG_9       = 8'hF6;
  localparam logic [7:0] SEG_APAGADO = 8'h00;

  localparam logic [3:0] BCD_APAGADO  = 4'hE;
  localparam logic [3:0] BCD_INVALIDO = 4'hF;

  typedef enum logic [1:0] {OCIOSO, CONTANDO, CAPTURADO} estado_e;

  // Bit width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned largura_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_decod.sv
// Combinational 7-segment pattern to BCD decoder; dp is not an input.
// Blank decodes to BCD_APAGADO, any unknown pattern to BCD_INVALIDO with invalido_o set.
module seg7_decod
  import seg7_pkg::*;
(
  input  logic [0:6] padrao_i,
  output logic [3:0] bcd_o,
  output logic       invalido_o
);

  logic [7:0] codigo;
  assign codigo = {padrao_i, 1'b0};

  always_comb begin
    bcd_o      = BCD_INVALIDO;
    invalido_o = 1'b0;
    case (codigo)
      SEG_0:       bcd_o = 4'd0;
      SEG_1:       bcd_o = 4'd1;
      SEG_2:       bcd_o = 4'd2;
      SEG_3:       bcd_o = 4'd3;
      SEG_4:       bcd_o = 4'd4;
      SEG_5:       bcd_o = 4'd5;
      SEG_6:       bcd_o = 4'd6;
      SEG_7:       bcd_o = 4'd7;
      SEG_8:       bcd_o = 4'd8;
      SEG_9:       bcd_o = 4'd9;
      SEG_APAGADO: bcd_o = BCD_APAGADO;
      default:     invalido_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_para_bcd.sv
// Samples a multiplexed 7-segment bus, commits each stable digit and assembles N-digit frames
// for a valid/ack consumer. Define SEG7_PONTO_EN to track and latch the decimal points.
module seg7_para_bcd
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITOS = 4,
  parameter int unsigned ESTAVEL   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [0:7]                           seg,
  input  logic [N_DIGITOS-1:0]                 an,
  output logic [3:0]                           digito,
  output logic [largura_min1(N_DIGITOS)-1:0]   indice,
  output logic                                 novo,
  output logic [4*N_DIGITOS-1:0]               quadro,
  output logic [N_DIGITOS-1:0]                 pontos,
  output logic [N_DIGITOS-1:0]                 erros,
  output logic                                 quadro_valido,
  input  logic                                 quadro_ack,
  output logic                                 perdido
);

  localparam int unsigned IW = largura_min1(N_DIGITOS);
  localparam int unsigned CW = largura_min1(ESTAVEL);
  localparam logic [CW-1:0] CntMax = CW'(ESTAVEL - 1);

  estado_e                state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N_DIGITOS-1:0]   s_an_q;
  logic [0:6]             s_seg_q;
  logic                   mudou, commit, completo;
  logic [IW-1:0]          s_idx;
  logic [3:0]             dec_bcd;
  logic                   dec_inv;

  logic [N_DIGITOS-1:0]   mask_q, mask_d;
  logic [4*N_DIGITOS-1:0] wrk_bcd_q, wrk_bcd_d, quadro_q, quadro_d;
  logic [N_DIGITOS-1:0]   wrk_err_q, wrk_err_d, erros_q, erros_d;
  logic [3:0]             digito_q, digito_d;
  logic [IW-1:0]          indice_q, indice_d;
  logic                   novo_q, novo_d, valido_q, valido_d, perdido_q, perdido_d;

  seg7_decod u_decod (
    .padrao_i   (s_seg_q),
    .bcd_o      (dec_bcd),
    .invalido_o (dec_inv)
  );

  always_comb begin
    s_idx = '0;
    for (int i = 0; i < int'(N_DIGITOS); i++) begin
      if (s_an_q[i]) s_idx = s_idx | IW'(i);
    end
  end

  // Stability counter and FSM; a sample change always restarts the window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (mudou) begin
      state_d = $onehot(an) ? CONTANDO : OCIOSO;
      cnt_d   = '0;
    end else begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      if (state_q == CONTANDO && cnt_q == CntMax) begin
        commit  = 1'b1;
        state_d = CAPTURADO;
      end
    end
  end

  assign completo = commit && (&(mask_q | s_an_q));

  always_comb begin
    digito_d  = digito_q;
    indice_d  = indice_q;
    novo_d    = commit;
    wrk_bcd_d = wrk_bcd_q;
    wrk_err_d = wrk_err_q;
    mask_d    = mask_q;
    quadro_d  = quadro_q;
    erros_d   = erros_q;
    valido_d  = valido_q && !quadro_ack;
    perdido_d = 1'b0;
    if (commit) begin
      digito_d  = dec_bcd;
      indice_d  = s_idx;
      wrk_err_d = (wrk_err_q & ~s_an_q) | (s_an_q & {N_DIGITOS{dec_inv}});
      for (int i = 0; i < int'(N_DIGITOS); i++) begin
        if (s_an_q[i]) wrk_bcd_d[4*i +: 4] = dec_bcd;
      end
      mask_d = mask_q | s_an_q;
    end
    if (completo) begin
      quadro_d  = wrk_bcd_d;
      erros_d   = wrk_err_d;
      mask_d    = '0;
      valido_d  = 1'b1;
      // A coincident ack consumes the old frame, so nothing is lost.
      perdido_d = valido_q && !quadro_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      cnt_q     <= '0;
      s_an_q    <= '0;
      s_seg_q   <= '0;
      mask_q    <= '0;
      wrk_bcd_q <= '0;
      wrk_err_q <= '0;
      quadro_q  <= '0;
      erros_q   <= '0;
      digito_q  <= '0;
      indice_q  <= '0;
      novo_q    <= 1'b0;
      valido_q  <= 1'b0;
      perdido_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_an_q    <= an;
      s_seg_q   <= seg[0:6];
      mask_q    <= mask_d;
      wrk_bcd_q <= wrk_bcd_d;
      wrk_err_q <= wrk_err_d;
      quadro_q  <= quadro_d;
      erros_q   <= erros_d;
      digito_q  <= digito_d;
      indice_q  <= indice_d;
      novo_q    <= novo_d;
      valido_q  <= valido_d;
      perdido_q <= perdido_d;
    end
  end

`ifdef SEG7_PONTO_EN
  logic                 s_dp_q;
  logic [N_DIGITOS-1:0] wrk_dp_q, wrk_dp_d, pontos_q, pontos_d;

  assign mudou = (an != s_an_q) || (seg[0:6] != s_seg_q) || (seg[7] != s_dp_q);

  always_comb begin
    wrk_dp_d = wrk_dp_q;
    pontos_d = pontos_q;
    if (commit) wrk_dp_d = (wrk_dp_q & ~s_an_q) | (s_an_q & {N_DIGITOS{s_dp_q}});
    if (completo) pontos_d = wrk_dp_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_dp_q   <= 1'b0;
      wrk_dp_q <= '0;
      pontos_q <= '0;
    end else begin
      s_dp_q   <= seg[7];
      wrk_dp_q <= wrk_dp_d;
      pontos_q <= pontos_d;
    end
  end

  assign pontos = pontos_q;
`else
  logic unused_dp;
  assign unused_dp = seg[7];
  assign mudou     = (an != s_an_q) || (seg[0:6] != s_seg_q);
  assign pontos    = '0;
`endif

  assign digito        = digito_q;
  assign indice        = indice_q;
  assign novo          = novo_q;
  assign quadro        = quadro_q;
  assign erros         = erros_q;
  assign quadro_valido = valido_q;
  assign perdido       = perdido_q;

endmodule

// File: tb/tb_seg7_para_bcd.sv
// Directed bench for seg7_para_bcd (N_DIGITOS=4, ESTAVEL=3), hand-computed expectations.
module tb_seg7_para_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:7]  seg;
  logic [3:0]  an;
  logic [3:0]  digito;
  logic [1:0]  indice;
  logic        novo;
  logic [15:0] quadro;
  logic [3:0]  pontos, erros;
  logic        quadro_valido, quadro_ack, perdido;

  int errors = 0;
  int checks = 0;
  int novo_cnt, perd_cnt;
  logic [3:0] last_dig;
  logic [1:0] last_idx;
  logic       val_at_novo;

  seg7_para_bcd #(.N_DIGITOS(4), .ESTAVEL(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg           (seg),
    .an            (an),
    .digito        (digito),
    .indice        (indice),
    .novo          (novo),
    .quadro        (quadro),
    .pontos        (pontos),
    .erros         (erros),
    .quadro_valido (quadro_valido),
    .quadro_ack    (quadro_ack),
    .perdido       (perdido)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    novo_cnt = 0;
    perd_cnt = 0;
    last_dig = '0;
    last_idx = '0;
    val_at_novo = 1'b0;
  endtask

  task automatic apply(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    for (int i = 0; i < n; i++) begin
      tick();
      if (novo) begin
        novo_cnt++;
        last_dig = digito;
        last_idx = indice;
        val_at_novo = quadro_valido;
      end
      if (perdido) perd_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    an = '0;
    seg = '0;
    quadro_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clr();
  endtask

  task automatic test_reset();
    int early;
    clr();
    apply(4'b0001, 8'hDA, 5);
    checks++;
    if (digito !== 4'h2) begin errors++; $display("FAIL pre_reset_digit: got %h want 2", digito); end
    apply(4'b0010, 8'hF2, 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digito, indice, novo, quadro, pontos, erros, quadro_valido, perdido} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dig=%h idx=%h q=%h v=%b want all zero",
               digito, indice, quadro, quadro_valido);
    end
    tick();
    tick();
    rst_n = 1'b1;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (novo) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL reset_early_novo: got %0d want 0", early); end
    tick();
    checks++;
    if ({novo, indice, digito} !== {1'b1, 2'd1, 4'h3}) begin
      errors++;
      $display("FAIL reset_first_commit: got novo=%b idx=%0d dig=%h want 1 1 3", novo, indice, digito);
    end
    apply(4'b0100, 8'h66, 5);
    apply(4'b1000, 8'hB6, 5);
    checks++;
    if (quadro_valido !== 1'b0) begin
      errors++;
      $display("FAIL reset_mask_discard: got valid=%b want 0", quadro_valido);
    end
  endtask

  task automatic test_latency();
    int early;
    do_reset();
    an = 4'b0100;
    seg = 8'hBE;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (novo) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL latency_early: got %0d want 0", early); end
    tick();
    checks++;
    if ({novo, indice, digito} !== {1'b1, 2'd2, 4'h6}) begin
      errors++;
      $display("FAIL latency_commit: got novo=%b idx=%0d dig=%h want 1 2 6", novo, indice, digito);
    end
    tick();
    checks++;
    if (novo !== 1'b0) begin errors++; $display("FAIL latency_pulse: got %b want 0", novo); end
  endtask

  task automatic test_frame();
    do_reset();
    apply(4'b0001, 8'hDA, 5);
    apply(4'b0010, 8'hF2, 5);
    apply(4'b0100, 8'h66, 5);
    checks++;
    if (quadro_valido !== 1'b0) begin
      errors++;
      $display("FAIL frame_partial_valid: got %b want 0", quadro_valido);
    end
    apply(4'b1000, 8'hB6, 5);
    checks++;
    if (novo_cnt !== 4) begin errors++; $display("FAIL frame_novos: got %0d want 4", novo_cnt); end
    checks++;
    if (quadro !== 16'h5432) begin errors++; $display("FAIL frame_quadro: got %h want 5432", quadro); end
    checks++;
    if ({quadro_valido, val_at_novo, last_idx, erros, pontos} !== {1'b1, 1'b1, 2'd3, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL frame_flags: got v=%b vn=%b idx=%0d err=%b pt=%b want 1 1 3 0000 0000",
               quadro_valido, val_at_novo, last_idx, erros, pontos);
    end
    clr();
    apply(4'b1000, 8'hB6, 20);
    checks++;
    if (novo_cnt !== 0) begin errors++; $display("FAIL frame_hold_once: got %0d want 0", novo_cnt); end
  endtask

  task automatic test_glitch();
    do_reset();
    apply(4'b0001, 8'hDA, 2);
    apply(4'b0001, 8'hFE, 6);
    checks++;
    if ({novo_cnt[3:0], last_dig} !== {4'd1, 4'h8}) begin
      errors++;
      $display("FAIL glitch: got commits=%0d dig=%h want 1 8", novo_cnt, last_dig);
    end
  endtask

  task automatic test_invalid_blank();
    do_reset();
    apply(4'b0001, 8'h12, 5);
    checks++;
    if (last_dig !== 4'hF) begin errors++; $display("FAIL invalid_digit: got %h want F", last_dig); end
    apply(4'b0010, 8'h00, 5);
    checks++;
    if (last_dig !== 4'hE) begin errors++; $display("FAIL blank_digit: got %h want E", last_dig); end
    apply(4'b0100, 8'hFC, 5);
    apply(4'b1000, 8'h60, 5);
    checks++;
    if ({quadro, erros} !== {16'h10EF, 4'b0001}) begin
      errors++;
      $display("FAIL invalid_frame: got q=%h err=%b want 10EF 0001", quadro, erros);
    end
  endtask

  task automatic test_handshake();
    do_reset();
    apply(4'b0001, 8'h60, 5);
    apply(4'b0010, 8'hDA, 5);
    apply(4'b0100, 8'hF2, 5);
    apply(4'b1000, 8'h66, 5);
    checks++;
    if ({quadro, quadro_valido, perd_cnt[3:0]} !== {16'h4321, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL hs_frame_a: got q=%h v=%b lost=%0d want 4321 1 0", quadro, quadro_valido, perd_cnt);
    end
    apply(4'b0001, 8'hB6, 5);
    apply(4'b0010, 8'hBE, 5);
    apply(4'b0100, 8'hE0, 5);
    apply(4'b1000, 8'hFE, 5);
    checks++;
    if ({quadro, quadro_valido, perd_cnt[3:0]} !== {16'h8765, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL hs_overwrite: got q=%h v=%b lost=%0d want 8765 1 1", quadro, quadro_valido, perd_cnt);
    end
    clr();
    apply(4'b0001, 8'hF6, 5);
    apply(4'b0010, 8'hFC, 5);
    apply(4'b0100, 8'h60, 5);
    an = 4'b1000;
    seg = 8'hDA;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (perdido) perd_cnt++;
    end
    quadro_ack = 1'b1;
    tick();
    quadro_ack = 1'b0;
    checks++;
    if ({novo, quadro_valido, perdido, quadro} !== {1'b1, 1'b1, 1'b0, 16'h2109}) begin
      errors++;
      $display("FAIL hs_ack_coincident: got novo=%b v=%b lost=%b q=%h want 1 1 0 2109",
               novo, quadro_valido, perdido, quadro);
    end
    checks++;
    if (perd_cnt !== 0) begin errors++; $display("FAIL hs_frame_c_lost: got %0d want 0", perd_cnt); end
    quadro_ack = 1'b1;
    tick();
    checks++;
    if (quadro_valido !== 1'b0) begin errors++; $display("FAIL hs_ack: got %b want 0", quadro_valido); end
    tick();
    quadro_ack = 1'b0;
    checks++;
    if ({quadro_valido, quadro} !== {1'b0, 16'h2109}) begin
      errors++;
      $display("FAIL hs_ack_idle: got v=%b q=%h want 0 2109", quadro_valido, quadro);
    end
  endtask

  task automatic test_repeat_slot();
    do_reset();
    apply(4'b0001, 8'h60, 5);
    apply(4'b0001, 8'hE0, 5);
    apply(4'b0010, 8'hDA, 5);
    apply(4'b0100, 8'hF2, 5);
    apply(4'b1000, 8'h66, 5);
    checks++;
    if ({quadro, novo_cnt[3:0]} !== {16'h4327, 4'd5}) begin
      errors++;
      $display("FAIL repeat_slot: got q=%h commits=%0d want 4327 5", quadro, novo_cnt);
    end
  endtask

  task automatic test_anode_faults();
    do_reset();
    apply(4'b0000, 8'hFC, 10);
    apply(4'b0011, 8'hFC, 10);
    apply(4'b0000, 8'h60, 10);
    checks++;
    if ({novo_cnt[3:0], digito} !== {4'd0, 4'h0}) begin
      errors++;
      $display("FAIL anode_faults: got commits=%0d dig=%h want 0 0", novo_cnt, digito);
    end
  endtask

  task automatic test_pontos();
    int exp_commits;
    logic [3:0] exp_pontos;
`ifdef SEG7_PONTO_EN
    exp_commits = 2;
    exp_pontos  = 4'b0001;
`else
    exp_commits = 1;
    exp_pontos  = 4'b0000;
`endif
    do_reset();
    apply(4'b0001, 8'hFC, 5);
    apply(4'b0001, 8'hFD, 5);
    checks++;
    if ({novo_cnt, last_dig} !== {exp_commits, 4'h0}) begin
      errors++;
      $display("FAIL dp_stability: got commits=%0d dig=%h want %0d 0", novo_cnt, last_dig, exp_commits);
    end
    apply(4'b0010, 8'h60, 5);
    apply(4'b0100, 8'hDA, 5);
    apply(4'b1000, 8'hF2, 5);
    checks++;
    if ({quadro, pontos} !== {16'h3210, exp_pontos}) begin
      errors++;
      $display("FAIL dp_frame: got q=%h pt=%b want 3210 %b", quadro, pontos, exp_pontos);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    an = '0;
    seg = '0;
    quadro_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_frame();
    test_glitch();
    test_invalid_blank();
    test_handshake();
    test_repeat_slot();
    test_anode_faults();
    test_pontos();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
